// File: rtl/qeciphy_rx_align_pkg.sv
// Shared state encoding, default constants and counter sizing for the RX comma word aligner.
package qeciphy_rx_align_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SLIDE,
      ST_WAIT,
      ST_SEARCH,
      ST_VERIFY,
      ST_LOCKED,
      ST_FAIL
   } align_state_e;

   localparam logic [31:0] DEFAULT_COMMA        = 32'h0000_00BC;
   localparam int          DEFAULT_PULSE_CYCLES = 2;
   localparam int          DEFAULT_IDLE_CYCLES  = 32;

   // One spare bit above what max_value needs, so a counter can never wrap.
   function automatic int cnt_width(input int max_value);
      return $clog2(max_value + 1) + 1;
   endfunction

endpackage

// File: rtl/qeciphy_comma_detect.sv
// Registers one raw RX word and flags when the masked word equals the masked comma pattern.
module qeciphy_comma_detect
   import qeciphy_rx_align_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(DEFAULT_COMMA),
   parameter logic [DATA_WIDTH-1:0] MASK       = '1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   output logic                  o_hit
);

   logic [DATA_WIDTH-1:0] rx_data_q;

   // NOTE: the data register is reset as well, so a stale word cannot raise a hit right after rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data_q <= '0;
      end else begin
         rx_data_q <= i_rx_data;
      end
   end

   assign o_hit = ((rx_data_q ^ PATTERN) & MASK) == '0;

endmodule

// File: rtl/qeciphy_rx_wordaligner.sv
// Comma-based RX word aligner: pulses the transceiver slide until the comma sits on the
// word boundary, verifies it over several periods, then monitors and re-aligns on loss.
module qeciphy_rx_wordaligner
   import qeciphy_rx_align_pkg::*;
#(
   parameter int                       RX_DATA_WIDTH      = 32,
   parameter logic [RX_DATA_WIDTH-1:0] COMMA_PATTERN      = RX_DATA_WIDTH'(DEFAULT_COMMA),
   parameter logic [RX_DATA_WIDTH-1:0] COMMA_MASK         = '1,
   parameter int                       TX_PATTERN_LENGTH  = 6,
   parameter int                       SLIDE_PULSE_CYCLES = DEFAULT_PULSE_CYCLES,
   parameter int                       SLIDE_IDLE_CYCLES  = DEFAULT_IDLE_CYCLES,
   parameter int                       SLIDE_MAX          = 80,
   parameter int                       LOCK_MATCH_COUNT   = 8,
   parameter int                       UNLOCK_MISS_COUNT  = 4,
   parameter int                       RETRY_MAX          = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_enable,
   input  logic                     i_restart,
   input  logic                     i_rx_slide_rdy,
   input  logic [RX_DATA_WIDTH-1:0] i_rx_data,
   output logic                     o_rx_slide,
   output logic                     o_align_done,
   output logic                     o_align_fail,
   output logic                     o_link_lost,
   output logic [7:0]               o_slide_count,
   output logic [7:0]               o_relock_count
);

   localparam int TIMER_MAX_A = (SLIDE_PULSE_CYCLES > SLIDE_IDLE_CYCLES) ? SLIDE_PULSE_CYCLES
                                                                         : SLIDE_IDLE_CYCLES;
   localparam int TIMER_MAX   = (TIMER_MAX_A > TX_PATTERN_LENGTH) ? TIMER_MAX_A : TX_PATTERN_LENGTH;

   localparam int TIMER_W = cnt_width(TIMER_MAX);
   localparam int SLIDE_W = cnt_width(SLIDE_MAX);
   localparam int PHASE_W = cnt_width(TX_PATTERN_LENGTH);
   localparam int MATCH_W = cnt_width(LOCK_MATCH_COUNT);
   localparam int MISS_W  = cnt_width(UNLOCK_MISS_COUNT);
   localparam int RETRY_W = cnt_width(RETRY_MAX);

   localparam logic [TIMER_W-1:0] PULSE_LAST  = TIMER_W'(SLIDE_PULSE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] IDLE_LAST   = TIMER_W'(SLIDE_IDLE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] WINDOW_LAST = TIMER_W'(TX_PATTERN_LENGTH - 1);
   localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(TX_PATTERN_LENGTH - 1);
   localparam logic [SLIDE_W-1:0] SLIDE_LAST  = SLIDE_W'(SLIDE_MAX);
   localparam logic [MATCH_W-1:0] MATCH_LAST  = MATCH_W'(LOCK_MATCH_COUNT);
   localparam logic [MISS_W-1:0]  MISS_LAST   = MISS_W'(UNLOCK_MISS_COUNT);
   localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(RETRY_MAX);

   align_state_e       state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [SLIDE_W-1:0] slide_count_q, slide_count_d;
   logic [MATCH_W-1:0] match_count_q, match_count_d;
   logic [MISS_W-1:0]  miss_count_q, miss_count_d;
   logic [RETRY_W-1:0] retry_count_q, retry_count_d;
   logic               fail_sticky_q, fail_sticky_d;
   logic [7:0]         relock_count_q, relock_count_d;
   logic               link_lost_q, link_lost_d;
   logic               align_done_q;
   logic               align_fail_q;

   logic               hit;
   logic               boundary;
   logic [PHASE_W-1:0] phase_next;

   qeciphy_comma_detect #(
      .DATA_WIDTH (RX_DATA_WIDTH),
      .PATTERN    (COMMA_PATTERN),
      .MASK       (COMMA_MASK)
   ) u_comma_detect (
      .clk       (clk),
      .rst       (rst),
      .i_rx_data (i_rx_data),
      .o_hit     (hit)
   );

   // The boundary is the phase on which the registered word should hold the comma.
   assign boundary   = (phase_q == PHASE_LAST);
   assign phase_next = boundary ? '0 : phase_q + 1'b1;

   // NOTE: every variable gets its hold value before the case, so no path can infer a latch.
   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      phase_d        = phase_q;
      slide_count_d  = slide_count_q;
      match_count_d  = match_count_q;
      miss_count_d   = miss_count_q;
      retry_count_d  = retry_count_q;
      fail_sticky_d  = fail_sticky_q;
      relock_count_d = relock_count_q;
      link_lost_d    = 1'b0;

      if (i_restart) begin
         state_d       = ST_IDLE;
         retry_count_d = '0;
         fail_sticky_d = 1'b0;
      end else if (!i_enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               timer_d       = '0;
               phase_d       = '0;
               slide_count_d = '0;
               match_count_d = '0;
               miss_count_d  = '0;
               if (i_rx_slide_rdy && !fail_sticky_q) begin
                  state_d       = ST_SLIDE;
                  slide_count_d = SLIDE_W'(1);
               end
            end

            ST_SLIDE: begin
               if (timer_q == PULSE_LAST) begin
                  state_d = ST_WAIT;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end

            ST_WAIT: begin
               if (timer_q == IDLE_LAST) begin
                  if (i_rx_slide_rdy) begin
                     state_d = ST_SEARCH;
                     timer_d = '0;
                  end
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end

            ST_SEARCH: begin
               if (hit) begin
                  state_d       = ST_VERIFY;
                  phase_d       = '0;
                  match_count_d = '0;
               end else if (timer_q == WINDOW_LAST) begin
                  timer_d = '0;
                  if (slide_count_q == SLIDE_LAST) begin
                     state_d = ST_FAIL;
                  end else begin
                     state_d       = ST_SLIDE;
                     slide_count_d = slide_count_q + 1'b1;
                  end
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end

            ST_VERIFY: begin
               phase_d = phase_next;
               if (boundary) begin
                  if (hit) begin
                     match_count_d = match_count_q + 1'b1;
                     if (match_count_d == MATCH_LAST) begin
                        state_d       = ST_LOCKED;
                        miss_count_d  = '0;
                        retry_count_d = '0;
                     end
                  end else begin
                     state_d = ST_FAIL;
                  end
               end else if (hit) begin
                  state_d = ST_FAIL;
               end
            end

            ST_LOCKED: begin
               phase_d = phase_next;
               // A comma off the boundary is treated like a missing one rather than an instant failure.
               if (boundary && hit) begin
                  miss_count_d = '0;
               end else if (boundary || hit) begin
                  miss_count_d = miss_count_q + 1'b1;
                  if (miss_count_d == MISS_LAST) begin
                     state_d     = ST_IDLE;
                     link_lost_d = 1'b1;
                     if (relock_count_q != 8'hFF) begin
                        relock_count_d = relock_count_q + 8'd1;
                     end
                  end
               end
            end

            ST_FAIL: begin
               state_d       = ST_IDLE;
               retry_count_d = retry_count_q + 1'b1;
               if (retry_count_d == RETRY_LAST) begin
                  fail_sticky_d = 1'b1;
               end
            end

            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         timer_q        <= '0;
         phase_q        <= '0;
         slide_count_q  <= '0;
         match_count_q  <= '0;
         miss_count_q   <= '0;
         retry_count_q  <= '0;
         fail_sticky_q  <= 1'b0;
         relock_count_q <= '0;
         link_lost_q    <= 1'b0;
         align_done_q   <= 1'b0;
         align_fail_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         phase_q        <= phase_d;
         slide_count_q  <= slide_count_d;
         match_count_q  <= match_count_d;
         miss_count_q   <= miss_count_d;
         retry_count_q  <= retry_count_d;
         fail_sticky_q  <= fail_sticky_d;
         relock_count_q <= relock_count_d;
         link_lost_q    <= link_lost_d;
         align_done_q   <= (state_q == ST_LOCKED);
         align_fail_q   <= fail_sticky_q;
      end
   end

   assign o_rx_slide     = (state_q == ST_SLIDE);
   assign o_align_done   = align_done_q;
   assign o_align_fail   = align_fail_q;
   assign o_link_lost    = link_lost_q;
   assign o_slide_count  = 8'(slide_count_q);
   assign o_relock_count = relock_count_q;

endmodule

// File: tb/tb_qeciphy_rx_wordaligner.sv
// Directed bench for the RX word aligner: a small transceiver model places the comma every
// PERIOD words and only on the boundary once enough slides have been issued.
module tb_qeciphy_rx_wordaligner;

   localparam int           W      = 32;
   localparam int           PERIOD = 6;
   localparam logic [W-1:0] COMMA  = 32'h0000_00BC;
   localparam logic [W-1:0] SKEWED = 32'h0000_05E0;
   localparam logic [W-1:0] FILLER = 32'h1234_5678;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_enable;
   logic         i_restart;
   logic         i_rx_slide_rdy;
   logic [W-1:0] i_rx_data;
   logic         o_rx_slide;
   logic         o_align_done;
   logic         o_align_fail;
   logic         o_link_lost;
   logic [7:0]   o_slide_count;
   logic [7:0]   o_relock_count;

   int vectors     = 0;
   int miscompares = 0;

   int slides_seen = 0;
   int slide_width = 0;
   logic slide_prev = 1'b0;
   int bad_pulse   = 0;
   int lost_pulses = 0;
   int lost_cycles = 0;
   logic lost_prev = 1'b0;

   int slide_base  = 0;
   int align_after = 0;
   int drop_req    = 0;
   int drop_done   = 0;
   int extra_req   = 0;
   int extra_done  = 0;
   int word_idx    = 0;
   int max_slide_cnt = 0;

   qeciphy_rx_wordaligner dut (
      .clk            (clk),
      .rst            (rst),
      .i_enable       (i_enable),
      .i_restart      (i_restart),
      .i_rx_slide_rdy (i_rx_slide_rdy),
      .i_rx_data      (i_rx_data),
      .o_rx_slide     (o_rx_slide),
      .o_align_done   (o_align_done),
      .o_align_fail   (o_align_fail),
      .o_link_lost    (o_link_lost),
      .o_slide_count  (o_slide_count),
      .o_relock_count (o_relock_count)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return o_align_done;
         1:       return o_align_fail;
         2:       return o_link_lost;
         default: return o_rx_slide;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel, input int budget);
      int n;
      n = 0;
      while (sig(sel) !== 1'b1 && n < budget) begin
         tick();
         n++;
         if (int'(o_slide_count) > max_slide_cnt) max_slide_cnt = int'(o_slide_count);
      end
      check(tag, sig(sel), 1);
   endtask

   // Slide pulse and link-lost monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (o_rx_slide) begin
            if (!slide_prev) slides_seen++;
            slide_width++;
         end else if (slide_prev) begin
            if (slide_width != 2) bad_pulse++;
            slide_width = 0;
         end
         slide_prev = o_rx_slide;
         if (o_link_lost) begin
            lost_cycles++;
            if (!lost_prev) lost_pulses++;
         end
         lost_prev = o_link_lost;
      end
   end

   // Transceiver model: comma slots every PERIOD words; dropped or skewed on request.
   initial begin
      i_rx_data = FILLER;
      forever begin
         @(posedge clk);
         #1;
         word_idx++;
         if (word_idx % PERIOD == 0) begin
            if (drop_done < drop_req) begin
               drop_done++;
               i_rx_data = FILLER;
            end else if (slides_seen - slide_base >= align_after) begin
               i_rx_data = COMMA;
            end else begin
               i_rx_data = SKEWED;
            end
         end else if (word_idx % PERIOD == 3 && extra_done < extra_req) begin
            extra_done++;
            i_rx_data = COMMA;
         end else begin
            i_rx_data = FILLER;
         end
      end
   end

   initial begin
      int n;
      rst            = 1'b1;
      i_enable       = 1'b0;
      i_restart      = 1'b0;
      i_rx_slide_rdy = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_slide",        o_rx_slide,     0);
      check("rst_done",         o_align_done,   0);
      check("rst_fail",         o_align_fail,   0);
      check("rst_link_lost",    o_link_lost,    0);
      check("rst_slide_count",  o_slide_count,  0);
      check("rst_relock_count", o_relock_count, 0);

      // Enabled but transceiver not ready: must stay idle.
      i_enable = 1'b1;
      repeat (10) tick();
      check("no_rdy_slides", slides_seen, 0);

      // Comma already aligned: one slide, lock after 8 verified periods.
      slide_base     = slides_seen;
      align_after    = 0;
      i_rx_slide_rdy = 1'b1;
      wait_for("t1_slide_start", 3, 20);
      n = 0;
      while (o_rx_slide !== 1'b0 && n < 10) begin tick(); n++; end
      n = 0;
      while (o_align_done !== 1'b1 && n < 200) begin tick(); n++; end
      check("t1_lock_latency_ok", (n >= 82 && n <= 87), 1);
      check("t1_done",        o_align_done, 1);
      check("t1_slide_count", o_slide_count, 1);
      check("t1_slides_seen", slides_seen - slide_base, 1);
      check("t1_no_fail",     o_align_fail, 0);

      // Three missing boundary commas then a hit: stays locked.
      drop_req += 3;
      n = 0;
      while (drop_done < drop_req && n < 50) begin tick(); n++; end
      repeat (12) tick();
      check("t2_3miss_locked",  o_align_done, 1);
      check("t2_3miss_no_loss", lost_pulses, 0);

      // Four missing commas: link lost, relock.
      drop_req += 4;
      wait_for("t2_link_lost", 2, 60);
      check("t2_relock_count", o_relock_count, 1);
      tick();
      check("t2_loss_pulse_end", o_link_lost, 0);
      check("t2_done_dropped",   o_align_done, 0);
      wait_for("t2_relock", 0, 200);
      check("t2_relock_slides",  o_slide_count, 1);
      check("t2_loss_one_cycle", lost_cycles, 1);

      // Disable while locked (no loss pulse), then comma appears only after 5 slides.
      i_enable = 1'b0;
      repeat (3) tick();
      check("t3_disable_no_loss", lost_pulses, 1);
      check("t3_disable_done",    o_align_done, 0);
      slide_base  = slides_seen;
      align_after = 5;
      i_enable    = 1'b1;
      wait_for("t3_lock", 0, 600);
      check("t3_slide_count", o_slide_count, 5);
      check("t3_slides_seen", slides_seen - slide_base, 5);
      check("t3_no_fail",     o_align_fail, 0);

      // Extra comma at phase 2 during VERIFY: attempt fails, second attempt locks.
      i_enable = 1'b0;
      repeat (3) tick();
      slide_base  = slides_seen;
      align_after = 0;
      i_enable    = 1'b1;
      n = 0;
      while (slides_seen == slide_base && n < 20) begin tick(); n++; end
      repeat (45) tick();
      extra_req += 1;
      wait_for("t4_relock", 0, 400);
      check("t4_two_attempts",  slides_seen - slide_base, 2);
      check("t4_slide_count",   o_slide_count, 1);
      check("t4_no_sticky",     o_align_fail, 0);
      check("t4_pulse_widths",  bad_pulse, 0);

      // No comma at all: 3 attempts of 80 slides, then sticky failure.
      i_enable = 1'b0;
      repeat (3) tick();
      slide_base    = slides_seen;
      align_after   = 1000;
      max_slide_cnt = 0;
      i_enable      = 1'b1;
      wait_for("t5_sticky", 1, 12000);
      check("t5_total_slides",  slides_seen - slide_base, 240);
      check("t5_max_slide_cnt", max_slide_cnt, 80);
      check("t5_not_done",      o_align_done, 0);
      repeat (60) tick();
      check("t5_sticky_holds",  o_align_fail, 1);
      check("t5_no_more_slide", slides_seen - slide_base, 240);

      // Restart clears the sticky failure and alignment resumes.
      slide_base  = slides_seen;
      align_after = 0;
      i_restart   = 1'b1;
      tick();
      i_restart = 1'b0;
      tick();
      check("t5_restart_clears", o_align_fail, 0);
      wait_for("t5_lock_after_restart", 0, 300);

      // Enable dropped during SLIDE: slide deasserts on the next cycle.
      i_enable = 1'b0;
      repeat (3) tick();
      slide_base = slides_seen;
      i_enable   = 1'b1;
      wait_for("t6_slide_seen", 3, 20);
      i_enable = 1'b0;
      tick();
      check("t6_slide_drops", o_rx_slide, 0);
      repeat (5) tick();
      check("t6_one_slide",   slides_seen - slide_base, 1);
      check("t6_no_loss",     lost_pulses, 1);

      // Synchronous reset while locked clears every output.
      i_enable = 1'b1;
      wait_for("t7_lock", 0, 300);
      rst = 1'b1;
      tick();
      check("t7_slide",        o_rx_slide,     0);
      check("t7_done",         o_align_done,   0);
      check("t7_fail",         o_align_fail,   0);
      check("t7_link_lost",    o_link_lost,    0);
      check("t7_slide_count",  o_slide_count,  0);
      check("t7_relock_count", o_relock_count, 0);
      rst      = 1'b0;
      i_enable = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
